// File: rtl/tdc_meas_ctrl_pkg.sv
// tdc_meas_ctrl_pkg: sequencer state encoding and fine-code width helper shared by the TDC controller.
package tdc_meas_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, WAIT_START, WAIT_STOP, DECODE, DONE} stateT;

    function automatic int fineWidth(input int num);
        return $clog2(num + 1);
    endfunction

endpackage

// File: rtl/tdc_meas_ctrl_popcount.sv
// tdc_meas_ctrl_popcount: combinational ones count of a thermometer column.
// Counts every set tap, so bubbles in the code still give a sensible value in 0..NUM.
module tdc_meas_ctrl_popcount
    import tdc_meas_ctrl_pkg::*;
#(
    parameter int NUM = 12,
    localparam int FW = fineWidth(NUM)
) (
    input  logic [NUM-1:0] iTherm,
    output logic [FW-1:0]  oCount
);

    always_comb begin
        oCount = '0;
        for (int i = 0; i < NUM; i++) oCount = oCount + FW'(iTherm[i]);
    end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: arms the fine TDC, gates Start/Stop column enables on hit edges, counts coarse periods
// and hands out the decoded result over valid/ready. Optional stop timeout via TDC_TIMEOUT_EN.
module tdc_meas_ctrl
    import tdc_meas_ctrl_pkg::*;
#(
    parameter int NUM = 12,
    parameter int CW = 16,
`ifdef TDC_TIMEOUT_EN
    parameter int MAX_COARSE = 2**CW - 1,
`endif
    localparam int FW = fineWidth(NUM)
) (
    input  logic           clk,
    input  logic           iRst,
    input  logic           iArm,
    input  logic [NUM-1:0] iFirstFF,
    input  logic [NUM-1:0] iFFStart,
    input  logic [NUM-1:0] iFFStop,
    output logic           oStartEnable,
    output logic           oStopEnable,
    output logic           oBusy,
    output logic           oValid,
    input  logic           iReady,
    output logic [CW-1:0]  oCoarse,
    output logic [FW-1:0]  oFineStart,
    output logic [FW-1:0]  oFineStop,
    output logic           oTimeout
);

    stateT         state;
    logic          prevTap;
    logic          hit;
    logic          tmo;
    logic [CW-1:0] cnt;
    logic [FW-1:0] popStart;
    logic [FW-1:0] popStop;
    logic          unusedTaps;

    // Only tap 0 of the first column carries the hit edge
    assign unusedTaps = ^iFirstFF[NUM-1:1];
    assign hit = iFirstFF[0] & ~prevTap;

    tdc_meas_ctrl_popcount #(.NUM(NUM)) uPopStart (.iTherm(iFFStart), .oCount(popStart));
    tdc_meas_ctrl_popcount #(.NUM(NUM)) uPopStop  (.iTherm(iFFStop),  .oCount(popStop));

`ifdef TDC_TIMEOUT_EN
    assign tmo = (cnt == CW'(MAX_COARSE));
    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) oTimeout <= 1'b0;
        else if (state == WAIT_STOP && !hit && tmo) oTimeout <= 1'b1;
        else if (state == DONE && iReady) oTimeout <= 1'b0;
    end
`else
    assign tmo = 1'b0;
    assign oTimeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state        <= IDLE;
            prevTap      <= 1'b0;
            cnt          <= '0;
            oStartEnable <= 1'b0;
            oStopEnable  <= 1'b0;
            oBusy        <= 1'b0;
            oValid       <= 1'b0;
            oCoarse      <= '0;
            oFineStart   <= '0;
            oFineStop    <= '0;
        end else begin
            prevTap <= iFirstFF[0];
            case (state)
                IDLE: if (iArm) begin
                    state        <= WAIT_START;
                    oStartEnable <= 1'b1;
                    oBusy        <= 1'b1;
                end
                WAIT_START: if (hit) begin
                    state        <= WAIT_STOP;
                    oStartEnable <= 1'b0;
                    oStopEnable  <= 1'b1;
                    cnt          <= CW'(1);
                end
                WAIT_STOP: begin
                    if (hit) begin
                        state       <= DECODE;
                        oStopEnable <= 1'b0;
                    end else if (tmo) begin
                        state       <= DONE;
                        oStopEnable <= 1'b0;
                        oValid      <= 1'b1;
                        oCoarse     <= cnt;
                        oFineStart  <= popStart;
                        oFineStop   <= '0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DECODE: begin
                    state      <= DONE;
                    oValid     <= 1'b1;
                    oCoarse    <= cnt;
                    oFineStart <= popStart;
                    oFineStop  <= popStop;
                end
                DONE: if (iReady) begin
                    state  <= IDLE;
                    oValid <= 1'b0;
                    oBusy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// tb_tdc_meas_ctrl: directed and randomized measurements of tdc_meas_ctrl against an edge-list reference model.
// Build with TDC_TIMEOUT_EN defined to exercise the stop timeout (MAX_COARSE=20).
module tb_tdc_meas_ctrl;

    localparam int NUM = 12;
    localparam int CW = 16;
    localparam int FW = 4;
`ifdef TDC_TIMEOUT_EN
    localparam int MAXC = 20;
`else
    localparam int MAXC = 1 << 20;
`endif

    logic           clk = 1'b0;
    logic           iRst = 1'b1;
    logic           iArm = 1'b0;
    logic [NUM-1:0] iFirstFF = '0;
    logic [NUM-1:0] iFFStart = '0;
    logic [NUM-1:0] iFFStop = '0;
    logic           iReady = 1'b0;
    logic           oStartEnable, oStopEnable, oBusy, oValid, oTimeout;
    logic [CW-1:0]  oCoarse;
    logic [FW-1:0]  oFineStart, oFineStop;

    int  vectors = 0;
    int  errs = 0;
    bit  wav [200];

    always #5 clk = ~clk;

    tdc_meas_ctrl #(
        .NUM(NUM),
        .CW(CW)
`ifdef TDC_TIMEOUT_EN
        , .MAX_COARSE(MAXC)
`endif
    ) dut (
        .clk(clk), .iRst(iRst), .iArm(iArm), .iFirstFF(iFirstFF), .iFFStart(iFFStart), .iFFStop(iFFStop),
        .oStartEnable(oStartEnable), .oStopEnable(oStopEnable), .oBusy(oBusy), .oValid(oValid),
        .iReady(iReady), .oCoarse(oCoarse), .oFineStart(oFineStart), .oFineStop(oFineStop), .oTimeout(oTimeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit hitAt(input int k);
        return (k < 200) ? wav[k] : wav[199];
    endfunction

    // Hit level starts at pre and toggles at each of t1..t4
    task automatic setWav(input bit pre, input int t1, input int t2, input int t3, input int t4);
        for (int k = 0; k < 200; k++)
            wav[k] = pre ^ 1'(int'(k >= t1) + int'(k >= t2) + int'(k >= t3) + int'(k >= t4));
    endtask

    task automatic randWav(input bit pre);
        int  k = 0;
        bit  lvl = pre;
        while (k < 200) begin
            int len = $urandom_range(1, 6);
            repeat (len) if (k < 200) begin
                wav[k] = lvl;
                k++;
            end
            lvl = !lvl;
        end
    endtask

    // Cycle 0 is the arm cycle; a rising edge at k needs wav[k]=1 after wav[k-1]=0
    task automatic runMeas(input logic [NUM-1:0] colS, input logic [NUM-1:0] colT,
                           input int readyWait, input bit armInDone);
        int n = -1, m = -1, sEnd, vS, h;
        bit tmo;
        for (int k = 1; k < 200; k++) if (n < 0 && wav[k] && !wav[k-1]) n = k;
        for (int k = n + 1; k < 200; k++) if (m < 0 && wav[k] && !wav[k-1]) m = k;
        if (m < 0) m = 100000;
        tmo  = (m - n) > MAXC;
        sEnd = tmo ? n + MAXC : m;
        vS   = tmo ? sEnd + 1 : sEnd + 2;
        h    = vS + readyWait;
        iFirstFF = {NUM{wav[0]}};
        repeat (3) tick();
        for (int k = 0; k <= h + 2; k++) begin
            check("startEnable", 32'(oStartEnable), 32'(k >= 1 && k <= n));
            check("stopEnable", 32'(oStopEnable), 32'(k > n && k <= sEnd));
            check("busy", 32'(oBusy), 32'(k >= 1 && k <= h));
            check("valid", 32'(oValid), 32'(k >= vS && k <= h));
            if (k >= vS && k <= h) begin
                check("coarse", 32'(oCoarse), tmo ? 32'(MAXC) : 32'(m - n));
                check("fineStart", 32'(oFineStart), 32'($countones(colS)));
                check("fineStop", 32'(oFineStop), tmo ? 32'd0 : 32'($countones(colT)));
                check("timeout", 32'(oTimeout), 32'(tmo));
            end
            iArm     = (k == 0) || (armInDone && k >= vS && k <= h);
            iFirstFF = {NUM'($urandom) >> 1 << 1} | NUM'(hitAt(k));
            iFFStart = (k > n) ? colS : NUM'($urandom);
            iFFStop  = (k > sEnd) ? colT : NUM'($urandom);
            iReady   = (k < vS) ? 1'($urandom) : (k >= h);
            tick();
        end
        iArm   = 1'b0;
        iReady = 1'b0;
    endtask

    initial begin
        #2;
        check("rstBusy", 32'(oBusy), 32'd0);
        check("rstValid", 32'(oValid), 32'd0);
        check("rstEnables", 32'({oStartEnable, oStopEnable}), 32'd0);
        check("rstResult", 32'({oCoarse, oFineStart, oFineStop, oTimeout}), 32'd0);
        tick();
        iRst = 1'b0;
        tick();
        setWav(1'b0, 10, 13, 17, 20);
        runMeas(12'h00F, 12'h3FF, 0, 1'b0);
        setWav(1'b0, 5, 6, 7, 9);
        runMeas(12'h0FF, 12'h001, 1, 1'b0);
        setWav(1'b1, 4, 6, 9, 11);
        runMeas(12'h000, 12'hFFF, 2, 1'b0);
        setWav(1'b0, 10, 13, 17, 20);
        runMeas(12'h5A3, 12'h3C0, 5, 1'b1);
        setWav(1'b0, 3, 5, 130, 140);
        runMeas(12'h07F, 12'h01F, 0, 1'b0);
        // Reset while waiting for stop must drop enables and busy without a clock edge
        iFirstFF = '0;
        tick();
        iArm = 1'b1;
        tick();
        iArm = 1'b0;
        iFirstFF = 12'h001;
        tick();
        iFirstFF = '0;
        tick();
        check("midStopEnable", 32'(oStopEnable), 32'd1);
        #2;
        iRst = 1'b1;
        #1;
        check("midRstEnables", 32'({oStartEnable, oStopEnable}), 32'd0);
        check("midRstBusy", 32'(oBusy), 32'd0);
        check("midRstValid", 32'(oValid), 32'd0);
        tick();
        iRst = 1'b0;
        tick();
        setWav(1'b0, 2, 4, 8, 12);
        runMeas(12'h0F0, 12'h00F, 0, 1'b0);
        for (int t = 0; t < 25; t++) begin
            randWav(1'($urandom));
            runMeas(NUM'($urandom), NUM'($urandom), $urandom_range(0, 4), 1'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
